// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Contents: default data/address widths, the starvation counter width and
// the port-index enum used to steer the single RAM port.
package dmem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_H = 1'b1
  } port_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (core C, host H) and the arbiter.
// Ports (per side): req, we, addr, wdata in; gnt, rvalid, rdata out;
// plus the starve_cnt debug output.
// Modports: master = requester side (testbench / core+host), slave = arbiter.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int unsigned DW = DATA_W,
  parameter int unsigned AW = ADDR_W
);

  logic              c_req;
  logic              c_we;
  logic [AW-1:0]     c_addr;
  logic [DW-1:0]     c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DW-1:0]     c_rdata;

  logic              h_req;
  logic              h_we;
  logic [AW-1:0]     h_addr;
  logic [DW-1:0]     h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DW-1:0]     h_rdata;

  logic [CNT_W-1:0]  starve_cnt;

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output h_req, h_we, h_addr, h_wdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  starve_cnt
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  h_req, h_we, h_addr, h_wdata,
    output h_gnt, h_rvalid, h_rdata,
    output starve_cnt
  );

endinterface

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous RAM, 2**ADDR_W words of DATA_W bits.
// Ports: clk, rst_n (async active-low, clears every word and rdata),
//        en (access this cycle), we (1 = write), addr, wdata, rdata (registered,
//        updated only on enabled reads, otherwise holds).
module dmem_sp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a private single-port data memory.
// Core (C) has fixed priority; the host (H) is forced a grant once it has been
// denied STARVE_MAX consecutive cycles. One access per cycle, reads return one
// cycle after the grant with a single rvalid pulse on the owning port.
// Ports: clk, sys_rst_n (async active-low), bus (slave modport: per-port
//        req/we/addr/wdata in, gnt/rvalid/rdata out, starve_cnt debug out).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           sys_rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_MAX);

  logic              force_h;
  logic              h_gnt;
  logic              c_gnt;
  port_e             owner;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              c_rvalid_q, h_rvalid_q;
  logic [DATA_W-1:0] c_hold_q, h_hold_q;

  // Grants are combinational; reset gates them so nothing is issued while the
  // memory is being cleared.
  always_comb begin
    force_h = bus.h_req && (starve_q == StarveMax);
    h_gnt   = sys_rst_n && bus.h_req && (!bus.c_req || force_h);
    c_gnt   = sys_rst_n && bus.c_req && !h_gnt;
    owner   = h_gnt ? PORT_H : PORT_C;
  end

  always_comb begin
    ram_en    = c_gnt || h_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (owner)
      PORT_C: begin
        ram_we    = bus.c_we;
        ram_addr  = bus.c_addr;
        ram_wdata = bus.c_wdata;
      end
      PORT_H: begin
        ram_we    = bus.h_we;
        ram_addr  = bus.h_addr;
        ram_wdata = bus.h_wdata;
      end
      default: ;
    endcase
  end

  // Saturation at StarveMax is normally unreachable because the force takes
  // effect at that count, but it keeps the counter bounded regardless.
  always_comb begin
    starve_d = '0;
    if (bus.h_req && !h_gnt) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      starve_q   <= '0;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      c_hold_q   <= '0;
      h_hold_q   <= '0;
    end else begin
      starve_q   <= starve_d;
      c_rvalid_q <= c_gnt && !bus.c_we;
      h_rvalid_q <= h_gnt && !bus.h_we;
      // Capture the shared RAM output while it belongs to a port so that
      // port's rdata keeps its value after the other port reads.
      if (c_rvalid_q) c_hold_q <= ram_rdata;
      if (h_rvalid_q) h_hold_q <= ram_rdata;
    end
  end

  dmem_sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (sys_rst_n),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.c_gnt      = c_gnt;
  assign bus.h_gnt      = h_gnt;
  assign bus.c_rvalid   = c_rvalid_q;
  assign bus.h_rvalid   = h_rvalid_q;
  assign bus.c_rdata    = c_rvalid_q ? ram_rdata : c_hold_q;
  assign bus.h_rdata    = h_rvalid_q ? ram_rdata : h_hold_q;
  assign bus.starve_cnt = starve_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (STARVE_MAX = 4).
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk;
  logic sys_rst_n;
  int   n_cmp;
  int   n_err;

  dmem_arbiter_if #(.DW(DATA_W), .AW(ADDR_W)) bus ();

  dmem_arbiter #(
    .STARVE_MAX (4)
  ) u_dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_c(input logic req, input logic we, input logic [3:0] a,
                       input logic [15:0] d);
    bus.c_req = req; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d;
  endtask

  task automatic set_h(input logic req, input logic we, input logic [3:0] a,
                       input logic [15:0] d);
    bus.h_req = req; bus.h_we = we; bus.h_addr = a; bus.h_wdata = d;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    set_c(1'b1, 1'b0, 4'd0, 16'h0);
    set_h(1'b1, 1'b0, 4'd0, 16'h0);
    #2;
    n_cmp++; if (bus.c_gnt !== 1'b0) begin n_err++;
      $display("FAIL rst_c_gnt: got %b want 0", bus.c_gnt); end
    n_cmp++; if (bus.h_gnt !== 1'b0) begin n_err++;
      $display("FAIL rst_h_gnt: got %b want 0", bus.h_gnt); end
    n_cmp++; if ({bus.c_rvalid, bus.h_rvalid} !== 2'b00) begin n_err++;
      $display("FAIL rst_rvalid: got %b want 00", {bus.c_rvalid, bus.h_rvalid}); end
    n_cmp++; if ({bus.c_rdata, bus.h_rdata} !== 32'h0) begin n_err++;
      $display("FAIL rst_rdata: got %h want 0", {bus.c_rdata, bus.h_rdata}); end
    n_cmp++; if (bus.starve_cnt !== 4'd0) begin n_err++;
      $display("FAIL rst_starve: got %0d want 0", bus.starve_cnt); end
    set_c(1'b0, 1'b0, 4'd0, 16'h0);
    set_h(1'b0, 1'b0, 4'd0, 16'h0);
    #10 sys_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_core_rw();
    set_c(1'b1, 1'b1, 4'd3, 16'hBEEF); #1;
    n_cmp++; if ({bus.c_gnt, bus.h_gnt} !== 2'b10) begin n_err++;
      $display("FAIL core_wr_gnt: got %b want 10", {bus.c_gnt, bus.h_gnt}); end
    @(posedge clk); #1;
    n_cmp++; if (bus.c_rvalid !== 1'b0) begin n_err++;
      $display("FAIL core_wr_no_rvalid: got %b want 0", bus.c_rvalid); end
    set_c(1'b1, 1'b0, 4'd3, 16'h0); #1;
    n_cmp++; if (bus.c_gnt !== 1'b1) begin n_err++;
      $display("FAIL core_rd_gnt: got %b want 1", bus.c_gnt); end
    @(posedge clk); #1;
    set_c(1'b0, 1'b0, 4'd0, 16'h0);
    n_cmp++; if ({bus.c_rvalid, bus.h_rvalid} !== 2'b10) begin n_err++;
      $display("FAIL core_rd_rvalid: got %b want 10", {bus.c_rvalid, bus.h_rvalid}); end
    n_cmp++; if (bus.c_rdata !== 16'hBEEF) begin n_err++;
      $display("FAIL core_rd_data: got %h want beef", bus.c_rdata); end
    @(posedge clk); #1;
    n_cmp++; if (bus.c_rvalid !== 1'b0) begin n_err++;
      $display("FAIL core_rvalid_pulse: got %b want 0", bus.c_rvalid); end
    n_cmp++; if (bus.c_rdata !== 16'hBEEF) begin n_err++;
      $display("FAIL core_rdata_hold: got %h want beef", bus.c_rdata); end
  endtask

  task automatic test_host_rw();
    set_h(1'b1, 1'b1, 4'd15, 16'h1234); #1;
    n_cmp++; if ({bus.c_gnt, bus.h_gnt} !== 2'b01) begin n_err++;
      $display("FAIL host_wr_gnt: got %b want 01", {bus.c_gnt, bus.h_gnt}); end
    @(posedge clk); #1;
    set_h(1'b1, 1'b0, 4'd15, 16'h0); #1;
    n_cmp++; if (bus.h_gnt !== 1'b1) begin n_err++;
      $display("FAIL host_rd_gnt: got %b want 1", bus.h_gnt); end
    @(posedge clk); #1;
    set_h(1'b0, 1'b0, 4'd0, 16'h0);
    n_cmp++; if ({bus.c_rvalid, bus.h_rvalid} !== 2'b01) begin n_err++;
      $display("FAIL host_rd_rvalid: got %b want 01", {bus.c_rvalid, bus.h_rvalid}); end
    n_cmp++; if (bus.h_rdata !== 16'h1234) begin n_err++;
      $display("FAIL host_rd_data: got %h want 1234", bus.h_rdata); end
    n_cmp++; if (bus.c_rdata !== 16'hBEEF) begin n_err++;
      $display("FAIL host_keeps_c_rdata: got %h want beef", bus.c_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    logic [3:0] exp_cnt [6];
    exp_cnt[0] = 4'd0; exp_cnt[1] = 4'd1; exp_cnt[2] = 4'd2;
    exp_cnt[3] = 4'd3; exp_cnt[4] = 4'd4; exp_cnt[5] = 4'd0;
    set_c(1'b1, 1'b0, 4'd0, 16'h0);
    set_h(1'b1, 1'b0, 4'd15, 16'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if (bus.starve_cnt !== exp_cnt[k]) begin n_err++;
        $display("FAIL starve_cnt[%0d]: got %0d want %0d", k, bus.starve_cnt, exp_cnt[k]); end
      n_cmp++; if (bus.h_gnt !== (k == 4)) begin n_err++;
        $display("FAIL starve_h_gnt[%0d]: got %b want %b", k, bus.h_gnt, k == 4); end
      n_cmp++; if (bus.c_gnt !== (k != 4)) begin n_err++;
        $display("FAIL starve_c_gnt[%0d]: got %b want %b", k, bus.c_gnt, k != 4); end
      n_cmp++; if (bus.h_rvalid !== (k == 5)) begin n_err++;
        $display("FAIL starve_h_rvalid[%0d]: got %b want %b", k, bus.h_rvalid, k == 5); end
      @(posedge clk); #1;
    end
    set_h(1'b0, 1'b0, 4'd0, 16'h0);
    n_cmp++; if (bus.h_rdata !== 16'h1234) begin n_err++;
      $display("FAIL starve_h_rdata: got %h want 1234", bus.h_rdata); end
    set_c(1'b0, 1'b0, 4'd0, 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    set_c(1'b1, 1'b1, 4'd7, 16'h00AA);
    @(posedge clk); #1;
    set_c(1'b1, 1'b0, 4'd7, 16'h0);
    @(posedge clk); #1;
    set_c(1'b0, 1'b0, 4'd0, 16'h0);
    set_h(1'b1, 1'b0, 4'd7, 16'h0); #1;
    n_cmp++; if ({bus.c_rvalid, bus.h_rvalid} !== 2'b10) begin n_err++;
      $display("FAIL b2b_first_rvalid: got %b want 10", {bus.c_rvalid, bus.h_rvalid}); end
    n_cmp++; if (bus.c_rdata !== 16'h00AA) begin n_err++;
      $display("FAIL b2b_c_rdata: got %h want 00aa", bus.c_rdata); end
    n_cmp++; if (bus.h_gnt !== 1'b1) begin n_err++;
      $display("FAIL b2b_h_gnt: got %b want 1", bus.h_gnt); end
    @(posedge clk); #1;
    set_h(1'b0, 1'b0, 4'd0, 16'h0);
    n_cmp++; if ({bus.c_rvalid, bus.h_rvalid} !== 2'b01) begin n_err++;
      $display("FAIL b2b_second_rvalid: got %b want 01", {bus.c_rvalid, bus.h_rvalid}); end
    n_cmp++; if (bus.h_rdata !== 16'h00AA) begin n_err++;
      $display("FAIL b2b_h_rdata: got %h want 00aa", bus.h_rdata); end
    n_cmp++; if (bus.c_rdata !== 16'h00AA) begin n_err++;
      $display("FAIL b2b_c_rdata_hold: got %h want 00aa", bus.c_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_host_drop();
    set_c(1'b1, 1'b0, 4'd1, 16'h0);
    set_h(1'b1, 1'b0, 4'd2, 16'h0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) set_h(1'b0, 1'b0, 4'd0, 16'h0);
      #1;
      n_cmp++; if (bus.starve_cnt !== 4'(k)) begin n_err++;
        $display("FAIL drop_starve[%0d]: got %0d want %0d", k, bus.starve_cnt, k); end
      n_cmp++; if (bus.h_gnt !== 1'b0) begin n_err++;
        $display("FAIL drop_h_gnt[%0d]: got %b want 0", k, bus.h_gnt); end
      @(posedge clk); #1;
    end
    n_cmp++; if (bus.starve_cnt !== 4'd0) begin n_err++;
      $display("FAIL drop_starve_clear: got %0d want 0", bus.starve_cnt); end
    set_c(1'b0, 1'b0, 4'd0, 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [3:0] addrs [3];
    addrs[0] = 4'd3; addrs[1] = 4'd15; addrs[2] = 4'd7;
    set_c(1'b1, 1'b0, 4'd7, 16'h0);
    set_h(1'b1, 1'b0, 4'd7, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if ({bus.starve_cnt, bus.c_rvalid} !== {4'd2, 1'b1}) begin n_err++;
      $display("FAIL mid_pre: got cnt %0d rv %b want 2 1", bus.starve_cnt, bus.c_rvalid); end
    #1 sys_rst_n = 1'b0; #1;
    n_cmp++; if ({bus.c_gnt, bus.h_gnt, bus.c_rvalid} !== 3'b000) begin n_err++;
      $display("FAIL mid_rst_gnt_rv: got %b want 000", {bus.c_gnt, bus.h_gnt, bus.c_rvalid}); end
    n_cmp++; if (bus.starve_cnt !== 4'd0) begin n_err++;
      $display("FAIL mid_rst_starve: got %0d want 0", bus.starve_cnt); end
    set_c(1'b0, 1'b0, 4'd0, 16'h0);
    set_h(1'b0, 1'b0, 4'd0, 16'h0);
    #1 sys_rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      set_c(1'b1, 1'b0, addrs[k], 16'h0);
      @(posedge clk); #1;
      n_cmp++; if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 16'h0}) begin n_err++;
        $display("FAIL mid_clear[%0d]: got rv %b data %h want 1 0000", k, bus.c_rvalid,
                 bus.c_rdata); end
    end
    set_c(1'b0, 1'b0, 4'd0, 16'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_core_rw();
    test_host_rw();
    test_starvation();
    test_back_to_back();
    test_host_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port 16x16 data memory between two requesters: the CPU core (port C) and an external host/loader (port H).
- Grants one access per cycle. Core has fixed priority. A starvation counter forces a host grant after STARVE_MAX consecutive denied cycles.
- Sits between the multi-cycle core's load/store path and data memory. The memory array lives inside this block.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 4, address width; depth = 2**ADDR_W
- STARVE_MAX, 4, consecutive denied host-request cycles before the host is forced a grant (range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- c_req  in  1  core access request
- c_we  in  1  core write enable (1 = write, 0 = read)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  core granted this cycle (combinational)
- c_rvalid  out  1  core read data valid (registered)
- c_rdata  out  DATA_W  core read data
- h_req, h_we, h_addr, h_wdata  in  1/1/ADDR_W/DATA_W  host request fields, same meaning as core
- h_gnt  out  1  host granted this cycle (combinational)
- h_rvalid  out  1  host read data valid (registered)
- h_rdata  out  DATA_W  host read data
- starve_cnt  out  4  current host wait count (debug)

Behaviour:
- Reset (sys_rst_n = 0, asynchronous): all memory words = 0, c_rvalid = h_rvalid = 0, c_rdata = h_rdata = 0, starve_cnt = 0. c_gnt and h_gnt are forced to 0 while reset is low.
- Reset asserted mid-transaction: any pending rvalid is dropped and the memory is cleared. Requesters must re-issue.
- Grant selection (combinational, same cycle as request):
  - force_h = h_req && (starve_cnt == STARVE_MAX).
  - h_gnt = h_req && (!c_req || force_h).
  - c_gnt = c_req && !h_gnt.
  - At most one grant per cycle. No grant when there is no request.
- Request hold: a requester must hold req and its fields stable until it sees gnt. Fields are sampled on the clock edge where gnt = 1.
- Write on the granted edge: mem[addr] <= wdata. No rvalid is produced for writes.
- Read, 1-cycle latency:
  - On the granted edge, the owner's rdata <= mem[addr] and its rvalid <= 1.
  - The other port's rvalid <= 0.
  - rdata holds its last value while rvalid = 0.
- A read to an address written on the previous cycle returns the new data. No same-cycle read/write conflict exists because there is a single port.
- Starvation counter (registered):
  - h_req && !h_gnt: starve_cnt <= starve_cnt + 1, saturating at STARVE_MAX.
  - h_gnt, or !h_req: starve_cnt <= 0.
  - Back-to-back core requests therefore yield one host slot every STARVE_MAX+1 cycles.
- Pipelining: a new grant may be issued every cycle, including back-to-back grants to the same port. rvalid pulses once per granted read.
- Simultaneous events:
  - Forced host grant while core requests: core is denied and must hold its request.
  - Core gets the next cycle unless the host re-wins.
- There are no states beyond the starvation counter and the read-response registers. Arbitration is otherwise stateless.

Decomposition:
- Shared package dmem_pkg: DATA_W, ADDR_W defaults and a port-index enum {PORT_C, PORT_H}.
- One natural sub-module, dmem_sp_ram: a single-port synchronous RAM with async-reset clear (we, addr, wdata, rdata registered).
- The arbiter contains the grant logic, the starvation counter and rvalid steering.

Test Plan:
- Reset, then core writes mem[3] = 16'hBEEF and reads addr 3 -> c_gnt = 1 in the request cycle; next cycle c_rvalid = 1, c_rdata = 16'hBEEF; h_rvalid = 0.
- Host only: write mem[15] = 16'h1234 then read -> h_gnt = 1 immediately; h_rdata = 16'h1234 one cycle after the read grant.
- Core requests every cycle, host requests from cycle 0, STARVE_MAX = 4 -> starve_cnt = 0,1,2,3,4; host granted in cycle 4; c_gnt = 0 in cycle 4; starve_cnt = 0 in cycle 5.
- Both read the same address in consecutive cycles after a core write of 16'h00AA -> both rdata = 16'h00AA; rvalid pulses one cycle each on the correct port.
- Core read granted, sys_rst_n pulsed low before the next edge -> c_rvalid = 0, all memory reads back 0, starve_cnt = 0.
- Host drops h_req at starve_cnt = 2 -> starve_cnt returns to 0 next cycle; no host grant issued.
